// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//   Control-store sequencer for the ARC microprogrammed CPU. Holds the
//   microprogram counter (MPC) that addresses the microcode ROM and selects
//   the next MPC from the microword COND/JUMP fields, the PSR condition codes
//   and the instruction register.
//
//   Optional feature macro: SEQ_MEMWAIT_EN
//     defined   - WAIT state holds MPC/counter while a memory op is not ready
//     undefined - single-cycle memory assumed, SEQ_Stall_Out tied low
//
// Ports:
//   SEQ_CLOCK_50        in   system clock, rising-edge active
//   SEQ_RESET_InLow     in   asynchronous active-low reset
//   SEQ_MicroWord_In    in   microword for the current SEQ_Address_Out
//   SEQ_Flags_In        in   condition codes {n,z,v,c}
//   SEQ_IR_In           in   instruction register
//   SEQ_MemReady_In     in   memory ready (SEQ_MEMWAIT_EN only)
//   SEQ_Address_Out     out  MPC / ROM address
//   SEQ_Stall_Out       out  MPC held for memory
//   SEQ_CycleCount_Out  out  completed microcycle count
// ---------------------------------------------------------------------------
module micro_sequencer #(
    parameter int unsigned SEQ_ADDR_W = 11,
    parameter int unsigned SEQ_WORD_W = 41,
    parameter int unsigned SEQ_CNT_W  = 16
) (
    input  logic                  SEQ_CLOCK_50,
    input  logic                  SEQ_RESET_InLow,
    input  logic [SEQ_WORD_W-1:0] SEQ_MicroWord_In,
    input  logic [3:0]            SEQ_Flags_In,
    input  logic [31:0]           SEQ_IR_In,
    input  logic                  SEQ_MemReady_In,
    output logic [SEQ_ADDR_W-1:0] SEQ_Address_Out,
    output logic                  SEQ_Stall_Out,
    output logic [SEQ_CNT_W-1:0]  SEQ_CycleCount_Out
);

    // Microword field positions
    localparam int unsigned RD_BIT     = 19;
    localparam int unsigned WR_BIT     = 18;
    localparam int unsigned COND_MSB   = 13;
    localparam int unsigned COND_LSB   = 11;
    localparam int unsigned JUMP_MSB   = 10;
    localparam int unsigned DECODE_W   = 11;

    // Condition codes
    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    logic [SEQ_ADDR_W-1:0] mpc_q, mpc_d;
    logic [SEQ_CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]            cond;
    logic [SEQ_ADDR_W-1:0] jump_addr;
    logic [SEQ_ADDR_W-1:0] inc_addr;
    logic [SEQ_ADDR_W-1:0] decode_addr;
    logic [SEQ_ADDR_W-1:0] next_addr;

    assign cond        = SEQ_MicroWord_In[COND_MSB:COND_LSB];
    assign jump_addr   = SEQ_ADDR_W'(SEQ_MicroWord_In[JUMP_MSB:0]);
    assign inc_addr    = mpc_q + SEQ_ADDR_W'(1);
    // Opcode dispatch: {1, op, op3, 00} spaces routines four words apart
    assign decode_addr = SEQ_ADDR_W'(DECODE_W'({1'b1, SEQ_IR_In[31:30],
                                                SEQ_IR_In[24:19], 2'b00}));

    // Next-address selection
    always_comb begin
        next_addr = inc_addr;
        case (cond)
            COND_NEXT:   next_addr = inc_addr;
            COND_N:      next_addr = SEQ_Flags_In[3] ? jump_addr : inc_addr;
            COND_Z:      next_addr = SEQ_Flags_In[2] ? jump_addr : inc_addr;
            COND_V:      next_addr = SEQ_Flags_In[1] ? jump_addr : inc_addr;
            COND_C:      next_addr = SEQ_Flags_In[0] ? jump_addr : inc_addr;
            COND_IR13:   next_addr = SEQ_IR_In[13]   ? jump_addr : inc_addr;
            COND_JUMP:   next_addr = jump_addr;
            COND_DECODE: next_addr = decode_addr;
            default:     next_addr = inc_addr;
        endcase
    end

`ifdef SEQ_MEMWAIT_EN

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } seq_state_e;

    seq_state_e state_q, state_d;
    logic       stall_q, stall_d;
    logic       mem_op;

    // RD and WR together still count as one memory operation
    assign mem_op = SEQ_MicroWord_In[RD_BIT] | SEQ_MicroWord_In[WR_BIT];

    // Next state, MPC, counter and stall
    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_op && !SEQ_MemReady_In) begin
                    state_d = ST_WAIT;
                    stall_d = 1'b1;
                end else begin
                    mpc_d = next_addr;
                    cnt_d = cnt_q + SEQ_CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // next_addr keeps tracking live flags/IR while held
                if (SEQ_MemReady_In) begin
                    state_d = ST_RUN;
                    mpc_d   = next_addr;
                    cnt_d   = cnt_q + SEQ_CNT_W'(1);
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge SEQ_CLOCK_50 or negedge SEQ_RESET_InLow) begin
        if (!SEQ_RESET_InLow) begin
            state_q <= ST_RUN;
            mpc_q   <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign SEQ_Stall_Out = stall_q;

    logic unused_bits;
    assign unused_bits = ^{SEQ_MicroWord_In[40:20], SEQ_MicroWord_In[17:14],
                           SEQ_IR_In[29:25], SEQ_IR_In[18:14], SEQ_IR_In[12:0]};

`else

    // Single-cycle memory: advance every microcycle
    always_comb begin
        mpc_d = next_addr;
        cnt_d = cnt_q + SEQ_CNT_W'(1);
    end

    always_ff @(posedge SEQ_CLOCK_50 or negedge SEQ_RESET_InLow) begin
        if (!SEQ_RESET_InLow) begin
            mpc_q <= '0;
            cnt_q <= '0;
        end else begin
            mpc_q <= mpc_d;
            cnt_q <= cnt_d;
        end
    end

    assign SEQ_Stall_Out = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{SEQ_MicroWord_In[40:20], SEQ_MicroWord_In[17:14],
                           SEQ_IR_In[29:25], SEQ_IR_In[18:14], SEQ_IR_In[12:0],
                           SEQ_MemReady_In};

`endif

    assign SEQ_Address_Out    = mpc_q;
    assign SEQ_CycleCount_Out = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//   Self-checking bench: a ROM array feeds the sequencer, a behavioural model
//   tracks MPC/count/stall from the architectural rules, and a negedge
//   compare process checks the DUT every cycle. Directed literal checks pin
//   the model, followed by a randomized-ROM run.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

    logic        clk;
    logic        rst_n;
    logic [40:0] word;
    logic [3:0]  flags;
    logic [31:0] ir;
    logic        rdy;
    logic [10:0] addr;
    logic        stall;
    logic [15:0] count;

    logic [40:0] rom [2048];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int m_mpc   = 0;
    int m_cnt   = 0;
    int m_stall = 0;

    micro_sequencer dut (
        .SEQ_CLOCK_50       (clk),
        .SEQ_RESET_InLow    (rst_n),
        .SEQ_MicroWord_In   (word),
        .SEQ_Flags_In       (flags),
        .SEQ_IR_In          (ir),
        .SEQ_MemReady_In    (rdy),
        .SEQ_Address_Out    (addr),
        .SEQ_Stall_Out      (stall),
        .SEQ_CycleCount_Out (count)
    );

    assign word = rom[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic logic [40:0] mk(input bit rd, input bit wr,
                                       input int cond, input int jump);
        logic [40:0] w;
        w        = '0;
        w[19]    = rd;
        w[18]    = wr;
        w[13:11] = 3'(cond);
        w[10:0]  = 11'(jump);
        return w;
    endfunction

    // Architectural next-address rule
    function automatic int model_next(input logic [40:0] w, input logic [3:0] f,
                                      input logic [31:0] i, input int mpc);
        int cond;
        int jmp;
        int inc;
        bit take;
        cond = int'(w[13:11]);
        jmp  = int'(w[10:0]);
        inc  = (mpc + 1) % 2048;
        if (cond == 7)
            return 1024 + int'(i[31:30]) * 256 + int'(i[24:19]) * 4;
        case (cond)
            1:       take = f[3];
            2:       take = f[2];
            3:       take = f[1];
            4:       take = f[0];
            5:       take = i[13];
            6:       take = 1'b1;
            default: take = 1'b0;
        endcase
        return take ? jmp : inc;
    endfunction

    task automatic model_reset();
        m_mpc   = 0;
        m_cnt   = 0;
        m_stall = 0;
    endtask

    // One clock edge of the model, using the inputs presented before the edge
    task automatic model_edge();
        logic [40:0] w;
        bit hold;
        w    = rom[m_mpc];
        hold = 1'b0;
`ifdef SEQ_MEMWAIT_EN
        hold = (w[19] | w[18]) & ~rdy;
`endif
        if (hold) begin
            m_stall = 1;
        end else begin
            m_mpc   = model_next(w, flags, ir, m_mpc);
            m_cnt   = (m_cnt + 1) % 65536;
            m_stall = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("addr_vs_model",  int'(addr),  m_mpc);
            check("stall_vs_model", int'(stall), m_stall);
            check("count_vs_model", int'(count), m_cnt);
        end
    end

    initial begin
        rst_n = 1'b0;
        flags = 4'b0;
        ir    = 32'h0;
        rdy   = 1'b1;
        for (int i = 0; i < 2048; i++) rom[i] = '0;

        // Directed microprogram
        rom[3]    = mk(0, 0, 7, 0);
        rom[1792] = mk(0, 0, 5, 1794);
        rom[1793] = mk(0, 0, 6, 1792);
        rom[1794] = mk(1, 0, 0, 0);
        rom[1795] = mk(0, 0, 7, 0);
        rom[1600] = mk(0, 0, 2, 12);
        rom[12]   = mk(0, 0, 2, 12);
        rom[13]   = mk(0, 0, 6, 2047);
        rom[2047] = mk(0, 0, 0, 0);

        // Reset held 3 cycles
        model_reset();
        chk_en = 1'b1;
        repeat (3) cycle();
        check("reset_addr",  int'(addr),  0);
        check("reset_count", int'(count), 0);
        check("reset_stall", int'(stall), 0);
        rst_n = 1'b1;

        // Increment
        cycle(); check("inc1", int'(addr), 1);
        cycle(); check("inc2", int'(addr), 2);
        cycle(); check("inc3", int'(addr), 3);
        check("inc_count", int'(count), 3);

        // DECODE of ld
        ir = 32'hC200_2000;
        cycle(); check("decode_ld", int'(addr), 1792);

        // IR[13] conditional
        ir = 32'h0000_0000;
        cycle(); check("ir13_clear", int'(addr), 1793);
        cycle(); check("jump_back", int'(addr), 1792);
        ir = 32'h0000_2000;
        cycle(); check("ir13_set", int'(addr), 1794);
        check("count_at_1794", int'(count), 7);

        // Memory wait
        rdy = 1'b0;
`ifdef SEQ_MEMWAIT_EN
        repeat (4) begin
            cycle();
            check("wait_addr",  int'(addr),  1794);
            check("wait_stall", int'(stall), 1);
            check("wait_count", int'(count), 7);
        end
        rdy = 1'b1;
        cycle();
`else
        cycle();
`endif
        check("mem_release_addr",  int'(addr),  1795);
        check("mem_release_stall", int'(stall), 0);
        check("mem_release_count", int'(count), 8);
        rdy = 1'b1;

        // DECODE of addcc
        ir = 32'h8080_0000;
        cycle(); check("decode_addcc", int'(addr), 1600);

        // Z-flag branch taken then not taken
        flags = 4'b0100;
        cycle(); check("z_taken", int'(addr), 12);
        flags = 4'b0000;
        cycle(); check("z_not_taken", int'(addr), 13);

        // Unconditional jump and MPC wrap
        cycle(); check("jump_2047", int'(addr), 2047);
        cycle(); check("wrap_0", int'(addr), 0);
        check("count_after_wrap", int'(count), 13);

        // Reset mid-wait
        repeat (3) cycle();
        ir = 32'hC200_2000;
        cycle();
        cycle(); check("reach_1794", int'(addr), 1794);
        rdy = 1'b0;
        cycle();
`ifdef SEQ_MEMWAIT_EN
        check("pre_reset_stall", int'(stall), 1);
`endif
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_addr",  int'(addr),  0);
        check("async_rst_stall", int'(stall), 0);
        check("async_rst_count", int'(count), 0);
        cycle();
        rst_n = 1'b1;
        rdy   = 1'b1;

        // Randomized ROM and inputs
        for (int i = 0; i < 2048; i++) rom[i] = 41'({$urandom, $urandom});
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            flags = 4'($urandom);
            ir    = $urandom;
            rdy   = ($urandom_range(3) != 0);
            cycle();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
